// File: rtl/fetch_pc_sequencer_pkg.sv
// Package: fetch_seq_pkg
// Shared types and helpers for the fetch PC sequencer and its FTQ.
//   fseq_state_t : sequencer FSM states
//   ftq_entry_t  : one fetch target queue entry (PC only for now)
//   next_seq_pc  : sequential next-block address, wrapping at the PC width
package fetch_seq_pkg;

    // Storage width of an FTQ entry PC. The sequencer's XLEN defaults to this.
    localparam int FSEQ_PC_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fseq_state_t;

    // Kept as a struct so commit-side fields (history, slot masks) can be added.
    typedef struct packed {
        logic [FSEQ_PC_W-1:0] pc;
    } ftq_entry_t;

    // Plain add; the carry out is dropped so the address wraps.
    function automatic logic [FSEQ_PC_W-1:0] next_seq_pc(
        input logic [FSEQ_PC_W-1:0] pc,
        input logic [FSEQ_PC_W-1:0] step
    );
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Interface: fetch_pc_sequencer_if
// Bundles the fetch-unit / commit-side signals of fetch_pc_sequencer.
//   master : drives pc_in, start, stall_in, redirect_*, pred_*, ftq_deq
//   slave  : the sequencer; drives fetch_*, ftq_head_*, ftq_count, halted
// With FSEQ_PERF_CNT_EN defined, perf_blocks / perf_redirects /
// perf_stall_cycles are added as slave outputs.
interface fetch_pc_sequencer_if #(
    parameter int XLEN      = 32,
    parameter int FTQ_DEPTH = 8
);
    localparam int CW = $clog2(FTQ_DEPTH) + 1;

    logic [XLEN-1:0] pc_in;
    logic            start;
    logic            stall_in;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            pred_valid;
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_valid;
    logic            fetch_stall;
    logic            ftq_deq;
    logic            ftq_head_valid;
    logic [XLEN-1:0] ftq_head_pc;
    logic [CW-1:0]   ftq_count;
    logic            halted;
`ifdef FSEQ_PERF_CNT_EN
    logic [31:0]     perf_blocks;
    logic [31:0]     perf_redirects;
    logic [31:0]     perf_stall_cycles;
`endif

    modport master (
`ifdef FSEQ_PERF_CNT_EN
        input  perf_blocks, perf_redirects, perf_stall_cycles,
`endif
        output pc_in, start, stall_in, redirect_valid, redirect_pc,
        output pred_valid, pred_pc, ftq_deq,
        input  fetch_pc, fetch_valid, fetch_stall,
        input  ftq_head_valid, ftq_head_pc, ftq_count, halted
    );

    modport slave (
`ifdef FSEQ_PERF_CNT_EN
        output perf_blocks, perf_redirects, perf_stall_cycles,
`endif
        input  pc_in, start, stall_in, redirect_valid, redirect_pc,
        input  pred_valid, pred_pc, ftq_deq,
        output fetch_pc, fetch_valid, fetch_stall,
        output ftq_head_valid, ftq_head_pc, ftq_count, halted
    );

endinterface

// File: rtl/fetch_pc_sequencer_ftq_fifo.sv
// Module: ftq_fifo
// Circular FIFO of ftq_entry_t used as the fetch target queue.
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_data     : enqueue (ignored when full)
//   pop                 : dequeue head (ignored when empty)
//   flush               : empty the queue; overrides push and pop
//   head_data/head_valid: oldest entry and non-empty flag
//   count, full         : occupancy and full flag (current count)
module ftq_fifo import fetch_seq_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  ftq_entry_t                 push_data,
    input  logic                       pop,
    input  logic                       flush,
    output ftq_entry_t                 head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    ftq_entry_t    mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full       = (count_r == CNT_FULL);
    assign head_valid = (count_r != '0);
    assign push_ok_s  = push && !full;
    assign pop_ok_s   = pop && head_valid;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed while the slot is occupied.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Module: fetch_pc_sequencer
// Fetch-block PC generator: picks the next block PC (commit redirect >
// predictor > sequential), records every issued block in the FTQ and runs
// the IDLE -> RUN -> DRAIN -> HALTED start-up / program-end sequence.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_pc_sequencer_if.slave (start/pc_in, stall_in, redirect,
//              prediction, fetch_pc/fetch_valid/fetch_stall, FTQ head/deq/
//              count, halted)
// Optional: define FSEQ_PERF_CNT_EN for saturating perf counters on the bus.
module fetch_pc_sequencer import fetch_seq_pkg::*; #(
    parameter int XLEN          = FSEQ_PC_W,
    parameter int FETCH_WIDTH   = 3,
    parameter int FTQ_DEPTH     = 8,
    parameter int PROG_END_ADDR = 132,
    parameter int HALT_DELAY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_pc_sequencer_if.slave   bus
);
    localparam int CW  = $clog2(FTQ_DEPTH) + 1;
    localparam int DCW = $clog2(HALT_DELAY) + 1;
    localparam logic [XLEN-1:0]      END_PC    = XLEN'(PROG_END_ADDR);
    localparam logic [FSEQ_PC_W-1:0] SEQ_STEP  = FSEQ_PC_W'(4 * FETCH_WIDTH);
    localparam logic [DCW-1:0]       HALT_LAST = DCW'(HALT_DELAY - 1);
    localparam logic [DCW-1:0]       DCNT_ONE  = DCW'(1);

    fseq_state_t          state_r;
    logic [XLEN-1:0]      fetch_pc_r;
    logic [XLEN-1:0]      head_hold_r;
    logic [DCW-1:0]       drain_cnt_r;
    logic                 halted_r;

    logic                 redirect_s;
    logic                 fire_s;
    logic [FSEQ_PC_W-1:0] seq_pc_s;
    logic [XLEN-1:0]      next_pc_s;
    ftq_entry_t           push_entry_s;
    ftq_entry_t           ftq_head_s;
    logic                 ftq_head_valid_s;
    logic                 ftq_full_s;
    logic [CW-1:0]        ftq_count_s;

    // A redirect arriving before the first start has nothing to correct.
    assign redirect_s = bus.redirect_valid && (state_r != IDLE);

    // Fire decision; full is judged on the current count so a same-cycle dequeue cannot free a slot.
    always_comb begin
        fire_s = 1'b0;
        if ((state_r == RUN) && !redirect_s && !bus.stall_in && !ftq_full_s && (fetch_pc_r < END_PC)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Next-PC mux and FTQ entry formation.
    always_comb begin
        seq_pc_s     = next_seq_pc(FSEQ_PC_W'(fetch_pc_r), SEQ_STEP);
        push_entry_s = '0;
        push_entry_s.pc = FSEQ_PC_W'(fetch_pc_r);
        if (bus.pred_valid) begin
            next_pc_s = bus.pred_pc;
        end else begin
            next_pc_s = seq_pc_s[XLEN-1:0];
        end
    end

    ftq_fifo #(
        .DEPTH (FTQ_DEPTH)
    ) u_ftq (
        .clk        (clk),
        .rst        (rst),
        .push       (fire_s),
        .push_data  (push_entry_s),
        .pop        (bus.ftq_deq && !redirect_s),
        .flush      (redirect_s),
        .head_data  (ftq_head_s),
        .head_valid (ftq_head_valid_s),
        .count      (ftq_count_s),
        .full       (ftq_full_s)
    );

    // Sequencer FSM: redirect overrides everything except IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            fetch_pc_r  <= '0;
            drain_cnt_r <= '0;
            halted_r    <= 1'b0;
        end else if (redirect_s) begin
            fetch_pc_r  <= bus.redirect_pc;
            drain_cnt_r <= '0;
            halted_r    <= 1'b0;
            state_r     <= (bus.redirect_pc >= END_PC) ? DRAIN : RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        fetch_pc_r <= bus.pc_in;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    if (fire_s) begin
                        fetch_pc_r <= next_pc_s;
                    end
                    if (fetch_pc_r >= END_PC) begin
                        state_r     <= DRAIN;
                        drain_cnt_r <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == HALT_LAST) begin
                        state_r  <= HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DCNT_ONE;
                    end
                end
                HALTED: begin
                    if (bus.start) begin
                        fetch_pc_r <= bus.pc_in;
                        halted_r   <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Remember the last valid head so ftq_head_pc holds once the queue empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_hold_r <= '0;
        end else if (ftq_head_valid_s) begin
            head_hold_r <= ftq_head_s.pc[XLEN-1:0];
        end else begin
            head_hold_r <= head_hold_r;
        end
    end

    assign bus.fetch_pc       = fetch_pc_r;
    assign bus.fetch_valid    = fire_s;
    assign bus.fetch_stall    = bus.stall_in | halted_r;
    assign bus.halted         = halted_r;
    assign bus.ftq_head_valid = ftq_head_valid_s;
    assign bus.ftq_head_pc    = ftq_head_valid_s ? ftq_head_s.pc[XLEN-1:0] : head_hold_r;
    assign bus.ftq_count      = ftq_count_s;

`ifdef FSEQ_PERF_CNT_EN
    logic [31:0] perf_blocks_r;
    logic [31:0] perf_redirects_r;
    logic [31:0] perf_stall_cycles_r;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_blocks_r       <= 32'd0;
            perf_redirects_r    <= 32'd0;
            perf_stall_cycles_r <= 32'd0;
        end else begin
            if (fire_s && (perf_blocks_r != 32'hFFFF_FFFF)) begin
                perf_blocks_r <= perf_blocks_r + 32'd1;
            end
            if (redirect_s && (perf_redirects_r != 32'hFFFF_FFFF)) begin
                perf_redirects_r <= perf_redirects_r + 32'd1;
            end
            if ((state_r == RUN) && !fire_s && (perf_stall_cycles_r != 32'hFFFF_FFFF)) begin
                perf_stall_cycles_r <= perf_stall_cycles_r + 32'd1;
            end
        end
    end

    assign bus.perf_blocks       = perf_blocks_r;
    assign bus.perf_redirects    = perf_redirects_r;
    assign bus.perf_stall_cycles = perf_stall_cycles_r;
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Testbench for fetch_pc_sequencer: scoreboard of expected fetch PCs and a
// queue model of FTQ contents, one task per scenario.
module tb_fetch_pc_sequencer;
    import fetch_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] exp_q [$];
    logic [31:0] ftq_m [$];
    logic [31:0] exp_pc;

    fetch_pc_sequencer_if #(.XLEN(32), .FTQ_DEPTH(8)) bus ();

    fetch_pc_sequencer #(
        .XLEN(32), .FETCH_WIDTH(3), .FTQ_DEPTH(8), .PROG_END_ADDR(132), .HALT_DELAY(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pc_in = 32'h0; bus.start = 1'b0; bus.stall_in = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.pred_valid = 1'b0; bus.pred_pc = 32'h0; bus.ftq_deq = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (bus.fetch_pc !== 32'h0) begin n_err++; $display("FAIL reset_fetch_pc: got %h want 0", bus.fetch_pc); end
        n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid: got %b want 0", bus.fetch_valid); end
        n_cmp++; if (bus.ftq_count !== 4'd0) begin n_err++; $display("FAIL reset_ftq_count: got %0d want 0", bus.ftq_count); end
        n_cmp++; if (bus.halted !== 1'b0 || bus.fetch_stall !== 1'b0) begin n_err++; $display("FAIL reset_halt_stall: got %b%b want 00", bus.halted, bus.fetch_stall); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        logic exp_v;
        bus.pc_in = 32'h0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_v = (i < 8);
            if (exp_v) begin
                exp_q.push_back(32'(12 * i));
                ftq_m.push_back(32'(12 * i));
            end
            #1;
            n_cmp++; if (bus.fetch_valid !== exp_v) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want %b", i, bus.fetch_valid, exp_v); end
            n_cmp++; if (bus.ftq_count !== 4'((i < 8) ? i : 8)) begin n_err++; $display("FAIL seq_count[%0d]: got %0d want %0d", i, bus.ftq_count, (i < 8) ? i : 8); end
            if (bus.fetch_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL seq_unexpected_fetch: got %h want none", bus.fetch_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (bus.fetch_pc !== exp_pc) begin n_err++; $display("FAIL seq_pc: got %h want %h", bus.fetch_pc, exp_pc); end
                end
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL seq_missing: got %0d left want 0", exp_q.size()); end
        n_cmp++; if (bus.ftq_head_pc !== ftq_m[0]) begin n_err++; $display("FAIL seq_head: got %h want %h", bus.ftq_head_pc, ftq_m[0]); end
        exp_q.delete();
    endtask

    task automatic test_full_deq();
        bus.ftq_deq = 1'b1;
        #1;
        n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL full_no_fire: got %b want 0", bus.fetch_valid); end
        tick();
        bus.ftq_deq = 1'b0;
        void'(ftq_m.pop_front());
        #1;
        n_cmp++; if (bus.ftq_count !== 4'd7) begin n_err++; $display("FAIL full_deq_count: got %0d want 7", bus.ftq_count); end
        n_cmp++; if (bus.ftq_head_pc !== ftq_m[0]) begin n_err++; $display("FAIL full_deq_head: got %h want %h", bus.ftq_head_pc, ftq_m[0]); end
        n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h60) begin n_err++; $display("FAIL full_refire: got %b/%h want 1/60", bus.fetch_valid, bus.fetch_pc); end
        ftq_m.push_back(32'h60);
        tick();
        #1;
        n_cmp++; if (bus.ftq_count !== 4'd8) begin n_err++; $display("FAIL full_recount: got %0d want 8", bus.ftq_count); end
        n_cmp++; if (bus.fetch_pc !== 32'h6C) begin n_err++; $display("FAIL full_pc_next: got %h want 6c", bus.fetch_pc); end
        tick();
    endtask

    task automatic test_redirect();
        logic [31:0] hold_pc;
        bus.ftq_deq = 1'b1;
        tick();
        void'(ftq_m.pop_front());
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h24;
        #1;
        n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid_forced: got %b want 0", bus.fetch_valid); end
        hold_pc = ftq_m[0];
        tick();
        bus.redirect_valid = 1'b0;
        bus.ftq_deq = 1'b0;
        ftq_m.delete();
        #1;
        n_cmp++; if (bus.ftq_count !== 4'd0 || bus.ftq_head_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %0d/%b want 0/0", bus.ftq_count, bus.ftq_head_valid); end
        n_cmp++; if (bus.ftq_head_pc !== hold_pc) begin n_err++; $display("FAIL redir_head_hold: got %h want %h", bus.ftq_head_pc, hold_pc); end
        n_cmp++; if (bus.fetch_pc !== 32'h24 || bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL redir_pc: got %h/%b want 24/1", bus.fetch_pc, bus.fetch_valid); end
        bus.stall_in = 1'b1;
        #1;
        n_cmp++; if (bus.fetch_valid !== 1'b0 || bus.fetch_stall !== 1'b1) begin n_err++; $display("FAIL stall: got %b/%b want 0/1", bus.fetch_valid, bus.fetch_stall); end
        tick();
    endtask

    task automatic test_predict();
        logic [31:0] m_pc;
        logic        pv;
        bus.stall_in = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        m_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            pv = (i == 1);
            bus.pred_valid = pv;
            bus.pred_pc = 32'h40;
            exp_q.push_back(m_pc);
            ftq_m.push_back(m_pc);
            m_pc = pv ? 32'h40 : m_pc + 32'd12;
            #1;
            n_cmp++;
            if (bus.fetch_valid !== 1'b1) begin
                n_err++; $display("FAIL pred_valid[%0d]: got %b want 1", i, bus.fetch_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                if (bus.fetch_pc !== exp_pc) begin n_err++; $display("FAIL pred_pc[%0d]: got %h want %h", i, bus.fetch_pc, exp_pc); end
            end
            tick();
        end
        bus.pred_valid = 1'b0;
        bus.stall_in = 1'b1;
        exp_q.delete();
        for (int j = 0; j < 3; j++) begin
            bus.ftq_deq = 1'b1;
            #1;
            n_cmp++; if (bus.ftq_head_pc !== ftq_m[0]) begin n_err++; $display("FAIL pred_ftq_order[%0d]: got %h want %h", j, bus.ftq_head_pc, ftq_m[0]); end
            n_cmp++; if (bus.ftq_count !== 4'(3 - j)) begin n_err++; $display("FAIL pred_ftq_count[%0d]: got %0d want %0d", j, bus.ftq_count, 3 - j); end
            tick();
            void'(ftq_m.pop_front());
        end
        bus.ftq_deq = 1'b0;
        #1;
        n_cmp++; if (bus.ftq_count !== 4'd0 || bus.ftq_head_valid !== 1'b0) begin n_err++; $display("FAIL pred_drained: got %0d/%b want 0/0", bus.ftq_count, bus.ftq_head_valid); end
        tick();
    endtask

    task automatic test_drain();
        bus.stall_in = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h78;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h78) begin n_err++; $display("FAIL drain_last_fetch: got %b/%h want 1/78", bus.fetch_valid, bus.fetch_pc); end
        tick();
        #1;
        n_cmp++; if (bus.fetch_valid !== 1'b0 || bus.fetch_pc !== 32'h84) begin n_err++; $display("FAIL drain_end_pc: got %b/%h want 0/84", bus.fetch_valid, bus.fetch_pc); end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.halted !== 1'b0 || bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL drain_wait[%0d]: got %b/%b want 0/0", k, bus.halted, bus.fetch_valid); end
            tick();
        end
        #1;
        n_cmp++; if (bus.halted !== 1'b1 || bus.fetch_stall !== 1'b1) begin n_err++; $display("FAIL drain_halted: got %b/%b want 1/1", bus.halted, bus.fetch_stall); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h10;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.halted !== 1'b0 || bus.fetch_pc !== 32'h10 || bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL drain_resume: got %b/%h/%b want 0/10/1", bus.halted, bus.fetch_pc, bus.fetch_valid); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        repeat (4) tick();
        n_cmp++; if (bus.ftq_count !== 4'd5) begin n_err++; $display("FAIL mid_count: got %0d want 5", bus.ftq_count); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.fetch_pc !== 32'h0 || bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_fetch: got %h/%b want 0/0", bus.fetch_pc, bus.fetch_valid); end
        n_cmp++; if (bus.ftq_count !== 4'd0 || bus.ftq_head_valid !== 1'b0 || bus.ftq_head_pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_ftq: got %0d/%b/%h want 0/0/0", bus.ftq_count, bus.ftq_head_valid, bus.ftq_head_pc); end
        #2;
        rst = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h50;
        bus.ftq_deq = 1'b1;
        repeat (2) tick();
        bus.redirect_valid = 1'b0;
        bus.ftq_deq = 1'b0;
        #1;
        n_cmp++; if (bus.fetch_pc !== 32'h0 || bus.fetch_valid !== 1'b0 || bus.ftq_count !== 4'd0) begin n_err++; $display("FAIL idle_ignore: got %h/%b/%0d want 0/0/0", bus.fetch_pc, bus.fetch_valid, bus.ftq_count); end
        bus.pc_in = 32'h20;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        n_cmp++; if (bus.fetch_pc !== 32'h20 || bus.fetch_valid !== 1'b1) begin n_err++; $display("FAIL restart: got %h/%b want 20/1", bus.fetch_pc, bus.fetch_valid); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sequential();
        test_full_deq();
        test_redirect();
        test_predict();
        test_drain();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
